upsp_frame_sequencer: RTL and testbench

Frame-level controller for the bicubic upsampling path. It starts a frame when the config register file raises UPSTART, then gates source-pixel delivery to the upsampler. It counts source pixels (AC→upsampler) and destination pixels (upsampler→AC), runs a stall watchdog, and writes the frame-completion or error status back into the config register file through the AC-side CRF write port. It sits beside access_control and arbitrates nothing; it only sequences.

---
 rtl/upsp_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_upsp_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsp_frame_sequencer.sv
// upsp_frame_sequencer
//
// Frame-level controller for the bicubic upsampling path. A rising edge on
// crf_ac_UPSTART starts a frame. While the frame runs, the block permits
// source-pixel delivery until the source total has been seen. It counts
// destination pixels until the destination total has been seen, and a stall
// watchdog guards the frame. The completion status or the error status is
// written back into the config register file through the AC-side CRF write
// port. The block does not arbitrate anything; it only sequences.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   crf_ac_UPSTART    start level from the CRF (edge-detected internally)
//   crf_ac_wbusy      CRF write port busy; the status write waits while high
//   ac_upsp_rvalid    observed source-pixel valid   (AC -> upsampler)
//   upsp_ac_rready    observed source-pixel ready
//   upsp_ac_wvalid    observed destination-pixel valid (upsampler -> AC)
//   ac_upsp_wready    observed destination-pixel ready
//   seq_rd_en         permits access_control to present source pixels
//   seq_wr_en         permits access_control to accept destination pixels
//   ac_crf_wrt        one-cycle CRF write strobe
//   ac_crf_waddr      CRF write address (zero when no strobe)
//   ac_crf_wdata      CRF write data: 1 done, 3 done with overflow, 2 timeout
//   seq_busy          high while running or reporting
//   seq_err           sticky error (timeout or overflow)
//   seq_ovf           sticky: handshake seen beyond the frame total
module upsp_frame_sequencer #(
   parameter int                          CRF_DATA_WIDTH = 32,
   parameter int                          CRF_ADDR_WIDTH = 12,
   parameter int                          SRC_IMG_WIDTH  = 960,
   parameter int                          SRC_IMG_HEIGHT = 540,
   parameter int                          DST_IMG_WIDTH  = 3840,
   parameter int                          DST_IMG_HEIGHT = 2160,
   parameter logic [CRF_ADDR_WIDTH-1:0]   UPEND_ADDR     = 12'h004,
   parameter int                          TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       crf_ac_UPSTART,
   input  logic                       crf_ac_wbusy,
   input  logic                       ac_upsp_rvalid,
   input  logic                       upsp_ac_rready,
   input  logic                       upsp_ac_wvalid,
   input  logic                       ac_upsp_wready,
   output logic                       seq_rd_en,
   output logic                       seq_wr_en,
   output logic                       ac_crf_wrt,
   output logic [CRF_ADDR_WIDTH-1:0]  ac_crf_waddr,
   output logic [CRF_DATA_WIDTH-1:0]  ac_crf_wdata,
   output logic                       seq_busy,
   output logic                       seq_err,
   output logic                       seq_ovf
);

   localparam int SRC_TOTAL = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
   localparam int DST_TOTAL = DST_IMG_WIDTH * DST_IMG_HEIGHT;
   localparam int SRC_CW    = $clog2(SRC_TOTAL + 1);
   localparam int DST_CW    = $clog2(DST_TOTAL + 1);
   localparam int TMR_W     = $clog2(TIMEOUT_CYCLES);

   localparam logic [SRC_CW-1:0] SRC_MAX  = SRC_CW'(SRC_TOTAL);
   localparam logic [DST_CW-1:0] DST_MAX  = DST_CW'(DST_TOTAL);
   localparam logic [DST_CW-1:0] DST_LAST = DST_CW'(DST_TOTAL - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [CRF_DATA_WIDTH-1:0] STAT_DONE     = CRF_DATA_WIDTH'(1);
   localparam logic [CRF_DATA_WIDTH-1:0] STAT_TIMEOUT  = CRF_DATA_WIDTH'(2);
   localparam logic [CRF_DATA_WIDTH-1:0] STAT_DONE_OVF = CRF_DATA_WIDTH'(3);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t                      state_q,   state_d;
   logic [SRC_CW-1:0]           src_cnt_q, src_cnt_d;
   logic [DST_CW-1:0]           dst_cnt_q, dst_cnt_d;
   logic [TMR_W-1:0]            timer_q,   timer_d;
   logic                        rd_en_q,   rd_en_d;
   logic                        err_q,     err_d;
   logic                        ovf_q,     ovf_d;
   logic                        wr_pend_q, wr_pend_d;
   logic [CRF_DATA_WIDTH-1:0]   status_q,  status_d;
   logic                        upstart_q;

   logic start;
   logic rd_fire;
   logic wr_fire;
   logic crf_wr;

   assign start   = crf_ac_UPSTART & ~upstart_q;
   assign rd_fire = ac_upsp_rvalid & upsp_ac_rready;
   assign wr_fire = upsp_ac_wvalid & ac_upsp_wready;

   // The status write goes out in the very cycle the CRF port is free, so the
   // strobe is the pending flag qualified by the live busy input.
   assign crf_wr  = wr_pend_q & ~crf_ac_wbusy;

   always_comb begin
      state_d   = state_q;
      src_cnt_d = src_cnt_q;
      dst_cnt_d = dst_cnt_q;
      timer_d   = timer_q;
      rd_en_d   = 1'b0;
      err_d     = err_q;
      ovf_d     = ovf_q;
      wr_pend_d = wr_pend_q;
      status_d  = status_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               src_cnt_d = '0;
               dst_cnt_d = '0;
               timer_d   = '0;
               err_d     = 1'b0;
               ovf_d     = 1'b0;
            end
         end

         ST_RUN: begin
            // Counters saturate at the frame total; an extra handshake is
            // flagged rather than counted.
            if (rd_fire) begin
               if (src_cnt_q == SRC_MAX) begin
                  ovf_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  src_cnt_d = src_cnt_q + 1'b1;
               end
            end
            if (wr_fire) begin
               if (dst_cnt_q == DST_MAX) begin
                  ovf_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  dst_cnt_d = dst_cnt_q + 1'b1;
               end
            end

            // Completion wins over a watchdog expiry in the same cycle.
            if (wr_fire && (dst_cnt_q == DST_LAST)) begin
               state_d   = ST_REPORT;
               wr_pend_d = 1'b1;
               status_d  = ovf_d ? STAT_DONE_OVF : STAT_DONE;
            end else if (!rd_fire && !wr_fire && (timer_q == TMR_LAST)) begin
               state_d   = ST_ERROR;
               err_d     = 1'b1;
               wr_pend_d = 1'b1;
               status_d  = STAT_TIMEOUT;
            end else begin
               timer_d = (rd_fire || wr_fire) ? '0 : timer_q + 1'b1;
               // Looks at the updated count so the permit drops right after
               // the last source pixel of the frame.
               rd_en_d = (src_cnt_d != SRC_MAX);
            end
         end

         ST_REPORT: begin
            if (crf_wr) begin
               wr_pend_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         ST_ERROR: begin
            if (start) begin
               // A pending timeout write is abandoned when a new frame starts.
               state_d   = ST_RUN;
               src_cnt_d = '0;
               dst_cnt_d = '0;
               timer_d   = '0;
               err_d     = 1'b0;
               ovf_d     = 1'b0;
               wr_pend_d = 1'b0;
            end else if (crf_wr) begin
               wr_pend_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         src_cnt_q <= '0;
         dst_cnt_q <= '0;
         timer_q   <= '0;
         rd_en_q   <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         status_q  <= '0;
         upstart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_cnt_q <= src_cnt_d;
         dst_cnt_q <= dst_cnt_d;
         timer_q   <= timer_d;
         rd_en_q   <= rd_en_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         wr_pend_q <= wr_pend_d;
         status_q  <= status_d;
         upstart_q <= crf_ac_UPSTART;
      end
   end

   assign seq_rd_en    = rd_en_q;
   assign seq_wr_en    = (state_q == ST_RUN);
   assign seq_busy     = (state_q == ST_RUN) || (state_q == ST_REPORT);
   assign seq_err      = err_q;
   assign seq_ovf      = ovf_q;
   assign ac_crf_wrt   = crf_wr;
   assign ac_crf_waddr = crf_wr ? UPEND_ADDR : '0;
   assign ac_crf_wdata = crf_wr ? status_q   : '0;

endmodule

// File: tb/tb_upsp_frame_sequencer.sv
// Bench for upsp_frame_sequencer with a small frame: SRC 4x2, DST 16x8,
// watchdog of 16 idle cycles. Directed frame scenarios with random gaps are
// followed by a fully random phase. A behavioural model tracks the frame
// from the handshake counts and predicts every output each cycle.
module tb_upsp_frame_sequencer;

   localparam int SRC_T = 8;
   localparam int DST_T = 128;
   localparam int TO    = 16;

   // model phase codes
   localparam int P_IDLE = 0, P_RUN = 1, P_REPORT = 2, P_ERROR = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        crf_ac_UPSTART, crf_ac_wbusy;
   logic        ac_upsp_rvalid, upsp_ac_rready, upsp_ac_wvalid, ac_upsp_wready;
   logic        seq_rd_en, seq_wr_en, ac_crf_wrt, seq_busy, seq_err, seq_ovf;
   logic [11:0] ac_crf_waddr;
   logic [31:0] ac_crf_wdata;

   always #5 clk = ~clk;

   upsp_frame_sequencer #(
      .CRF_DATA_WIDTH (32),
      .CRF_ADDR_WIDTH (12),
      .SRC_IMG_WIDTH  (4),
      .SRC_IMG_HEIGHT (2),
      .DST_IMG_WIDTH  (16),
      .DST_IMG_HEIGHT (8),
      .UPEND_ADDR     (12'h004),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .crf_ac_UPSTART (crf_ac_UPSTART),
      .crf_ac_wbusy   (crf_ac_wbusy),
      .ac_upsp_rvalid (ac_upsp_rvalid),
      .upsp_ac_rready (upsp_ac_rready),
      .upsp_ac_wvalid (upsp_ac_wvalid),
      .ac_upsp_wready (ac_upsp_wready),
      .seq_rd_en      (seq_rd_en),
      .seq_wr_en      (seq_wr_en),
      .ac_crf_wrt     (ac_crf_wrt),
      .ac_crf_waddr   (ac_crf_waddr),
      .ac_crf_wdata   (ac_crf_wdata),
      .seq_busy       (seq_busy),
      .seq_err        (seq_err),
      .seq_ovf        (seq_ovf)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int strobes = 0;

   logic g_up = 1'b0;
   logic g_wb = 1'b0;

   // reference model of the frame
   int m_phase, m_src, m_dst, m_quiet, m_age, m_err, m_ovf, m_written, m_status, m_upprev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_src = 0; m_dst = 0; m_quiet = 0; m_age = 0;
      m_err = 0; m_ovf = 0; m_written = 1; m_status = 0; m_upprev = 0;
   endtask

   task automatic model_new_frame();
      m_phase = P_RUN; m_src = 0; m_dst = 0; m_quiet = 0; m_age = 0;
      m_err = 0; m_ovf = 0; m_written = 1;
   endtask

   // One clock cycle: apply inputs, check predicted outputs, advance model.
   task automatic step(input logic rv, input logic rr, input logic wv, input logic wr);
      bit rdf, wrf, start, e_wrt, e_busy, e_rden, e_wren, done;
      @(negedge clk);
      crf_ac_UPSTART = g_up;
      crf_ac_wbusy   = g_wb;
      ac_upsp_rvalid = rv;
      upsp_ac_rready = rr;
      upsp_ac_wvalid = wv;
      ac_upsp_wready = wr;
      #1;
      cyc++;
      rdf   = rv & rr;
      wrf   = wv & wr;
      start = g_up && (m_upprev == 0);
      e_wrt  = ((m_phase == P_REPORT) || (m_phase == P_ERROR)) && (m_written == 0) && !g_wb;
      e_busy = (m_phase == P_RUN) || (m_phase == P_REPORT);
      e_wren = (m_phase == P_RUN);
      e_rden = (m_phase == P_RUN) && (m_age > 0) && (m_src < SRC_T);

      chk("busy",  32'(seq_busy),   32'(e_busy));
      chk("rd_en", 32'(seq_rd_en),  32'(e_rden));
      chk("wr_en", 32'(seq_wr_en),  32'(e_wren));
      chk("err",   32'(seq_err),    32'(m_err));
      chk("ovf",   32'(seq_ovf),    32'(m_ovf));
      chk("wrt",   32'(ac_crf_wrt), 32'(e_wrt));
      chk("waddr", 32'(ac_crf_waddr), e_wrt ? 32'h4 : 32'h0);
      chk("wdata", ac_crf_wdata,    e_wrt ? 32'(m_status) : 32'h0);
      if (ac_crf_wrt === 1'b1) strobes++;

      done = 0;
      case (m_phase)
         P_IDLE: if (start) model_new_frame();
         P_RUN: begin
            if (rdf) begin
               if (m_src == SRC_T) begin m_ovf = 1; m_err = 1; end
               else m_src++;
            end
            if (wrf) begin
               if (m_dst == DST_T) begin m_ovf = 1; m_err = 1; end
               else begin m_dst++; done = (m_dst == DST_T); end
            end
            if (done) begin
               m_phase = P_REPORT; m_written = 0; m_status = m_ovf ? 3 : 1;
            end else if (!rdf && !wrf && (m_quiet == TO - 1)) begin
               m_phase = P_ERROR; m_err = 1; m_written = 0; m_status = 2;
            end else begin
               m_quiet = (rdf || wrf) ? 0 : m_quiet + 1;
               m_age++;
            end
         end
         P_REPORT: if (e_wrt) begin m_phase = P_IDLE; m_written = 1; end
         P_ERROR: begin
            if (start) model_new_frame();
            else if (e_wrt) m_written = 1;
         end
         default: ;
      endcase
      m_upprev = g_up;
   endtask

   task automatic rd_fire();
      step(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic wr_fire();
      step(1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   // cycles with random half-handshakes that never complete
   task automatic idle(input int n);
      logic a, b, c, d;
      for (int i = 0; i < n; i++) begin
         a = 1'($urandom);
         b = a ? 1'b0 : 1'($urandom);
         c = 1'($urandom);
         d = c ? 1'b0 : 1'($urandom);
         step(a, b, c, d);
      end
   endtask

   task automatic pulse_start();
      g_up = 1'b1; idle(1);
      g_up = 1'b0; idle(2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      g_up = 1'b0; g_wb = 1'b0;
      crf_ac_UPSTART = 1'b0; crf_ac_wbusy = 1'b0;
      ac_upsp_rvalid = 1'b0; upsp_ac_rready = 1'b0;
      upsp_ac_wvalid = 1'b0; ac_upsp_wready = 1'b0;
      #1;
      chk("rst_busy",  32'(seq_busy),   32'h0);
      chk("rst_rd_en", 32'(seq_rd_en),  32'h0);
      chk("rst_wr_en", 32'(seq_wr_en),  32'h0);
      chk("rst_err",   32'(seq_err),    32'h0);
      chk("rst_ovf",   32'(seq_ovf),    32'h0);
      chk("rst_wrt",   32'(ac_crf_wrt), 32'h0);
      chk("rst_waddr", 32'(ac_crf_waddr), 32'h0);
      chk("rst_wdata", ac_crf_wdata,    32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic src_phase(input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, maxgap));
         rd_fire();
      end
   endtask

   task automatic dst_phase(input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, maxgap));
         wr_fire();
      end
   endtask

   initial begin
      logic rv, rr, wv, wr;
      rst_n = 1'b0;
      do_reset();

      // nominal frame
      strobes = 0;
      pulse_start();
      src_phase(SRC_T, 6);
      idle(2);
      dst_phase(DST_T, 10);
      idle(4);
      chk("nominal_strobes", 32'(strobes), 32'd1);

      // CRF write port busy across frame end
      strobes = 0;
      pulse_start();
      src_phase(SRC_T, 3);
      dst_phase(DST_T - 1, 4);
      g_wb = 1'b1;
      wr_fire();
      idle(4);
      chk("bp_no_early_strobe", 32'(strobes), 32'd0);
      g_wb = 1'b0;
      idle(3);
      chk("bp_strobes", 32'(strobes), 32'd1);

      // watchdog, then restart from ERROR
      strobes = 0;
      pulse_start();
      dst_phase(50, 5);
      idle(30);
      chk("wd_strobes", 32'(strobes), 32'd1);
      pulse_start();
      src_phase(SRC_T, 0);
      idle(2);
      dst_phase(DST_T, 2);
      idle(3);
      chk("wd_restart_strobes", 32'(strobes), 32'd2);

      // source overflow
      strobes = 0;
      pulse_start();
      src_phase(SRC_T + 1, 2);
      dst_phase(DST_T, 2);
      idle(3);
      chk("ovf_strobes", 32'(strobes), 32'd1);

      // UPSTART held high across completion, then re-armed by a toggle
      strobes = 0;
      g_up = 1'b1;
      idle(2);
      src_phase(SRC_T, 2);
      dst_phase(DST_T, 2);
      idle(10);
      chk("level_strobes", 32'(strobes), 32'd1);
      g_up = 1'b0; idle(1);
      g_up = 1'b1; idle(2);
      src_phase(5, 1);

      // reset in the middle of a frame
      strobes = 0;
      do_reset();
      idle(6);
      chk("rst_no_strobe", 32'(strobes), 32'd0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) g_up = ~g_up;
         g_wb = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) begin
            repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
         end
         rv = 1'($urandom); rr = 1'($urandom);
         wv = 1'($urandom); wr = ($urandom_range(0, 3) != 0);
         step(rv, rr, wv, wr);
      end
      g_wb = 1'b0;
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
